// File: rtl/multi_ball_hit_controller_if.sv
// Bus between the object drawers / ball movers and the multi-ball collision resolver.
// The controller takes the slave view; the drawer/mover side takes the master view.
interface multi_ball_hit_controller_if #(
   parameter int NUM_BALLS = 2,
   parameter int NUM_HOLES = 6
);
   logic                     startOfFrame;
   logic [10:0]              pixelX;
   logic [10:0]              pixelY;
   logic [NUM_BALLS-1:0]     ballDR;
   logic                     bordersDR;
   logic [NUM_HOLES-1:0]     holeDR;
   logic [NUM_BALLS*11-1:0]  ballVelX;
   logic [NUM_BALLS*11-1:0]  ballVelY;
   logic [NUM_BALLS*11-1:0]  ballVelXOut;
   logic [NUM_BALLS*11-1:0]  ballVelYOut;
   logic [NUM_BALLS-1:0]     collisionOccurred;
   logic [NUM_BALLS-1:0]     holeHit;
   logic [NUM_BALLS*3-1:0]   holeNum;
   logic                     resultValid;
   logic                     overrun;

   modport master (
      output startOfFrame, pixelX, pixelY, ballDR, bordersDR, holeDR, ballVelX, ballVelY,
      input  ballVelXOut, ballVelYOut, collisionOccurred, holeHit, holeNum, resultValid, overrun
   );

   modport slave (
      input  startOfFrame, pixelX, pixelY, ballDR, bordersDR, holeDR, ballVelX, ballVelY,
      output ballVelXOut, ballVelYOut, collisionOccurred, holeHit, holeNum, resultValid, overrun
   );
endinterface

// File: rtl/multi_ball_hit_controller.sv
// Per-frame collision resolver: accumulates ball/border/hole/ball pixel overlaps during a frame,
// snapshots them at startOfFrame, then resolves one ball per clock into registered velocities/flags.
module multi_ball_hit_controller #(
   parameter int NUM_BALLS    = 2,
   parameter int NUM_HOLES    = 6,
   parameter int TOP_OFFSET   = 0,
   parameter int DOWN_OFFSET  = 479,
   parameter int LEFT_OFFSET  = 0,
   parameter int RIGHT_OFFSET = 639,
   parameter int EDGE         = 8
) (
   input  logic                     clk,
   input  logic                     reset,
   multi_ball_hit_controller_if.slave bus
);
   localparam logic [1:0] COLLECT = 2'd0;
   localparam logic [1:0] RESOLVE = 2'd1;
   localparam logic [1:0] DONE    = 2'd2;
   localparam int IW = (NUM_BALLS > 1) ? $clog2(NUM_BALLS) : 1;

   logic [1:0]            state;
   logic [IW-1:0]         idx;
   logic                  overrun_q;

   logic [NUM_BALLS-1:0]  bord_hit;
   logic [10:0]           bord_x    [NUM_BALLS];
   logic [10:0]           bord_y    [NUM_BALLS];
   logic [NUM_HOLES-1:0]  hole_mask [NUM_BALLS];
   logic [NUM_BALLS-1:0]  pair      [NUM_BALLS];

   logic [NUM_BALLS-1:0]  s_bord;
   logic [10:0]           s_bx      [NUM_BALLS];
   logic [10:0]           s_by      [NUM_BALLS];
   logic [NUM_HOLES-1:0]  s_hole    [NUM_BALLS];
   logic [NUM_BALLS-1:0]  s_pair    [NUM_BALLS];
   logic signed [10:0]    s_vx      [NUM_BALLS];
   logic signed [10:0]    s_vy      [NUM_BALLS];

   logic signed [10:0]    o_vx      [NUM_BALLS];
   logic signed [10:0]    o_vy      [NUM_BALLS];
   logic [2:0]            o_hn      [NUM_BALLS];
   logic [NUM_BALLS-1:0]  o_coll;
   logic [NUM_BALLS-1:0]  o_hh;

   logic signed [10:0]    r_vx, r_vy;
   logic [2:0]            r_hn;
   logic                  r_coll, r_hh, found;
   logic [IW-1:0]         partner;
   logic                  sof;

   assign sof = bus.startOfFrame;

   // |v| with -1024 saturating to +1023, so negating the result never overflows
   function automatic logic signed [10:0] sat_abs(input logic signed [10:0] v);
      if (v == 11'sh400)
         return 11'sd1023;
      else if (v < 0)
         return -v;
      else
         return v;
   endfunction

   always_comb begin
      r_vx    = s_vx[idx];
      r_vy    = s_vy[idx];
      r_hn    = '0;
      r_coll  = 1'b0;
      r_hh    = 1'b0;
      found   = 1'b0;
      partner = '0;
      if (|s_hole[idx]) begin
         r_vx   = '0;
         r_vy   = '0;
         r_hh   = 1'b1;
         r_coll = 1'b1;
         for (int unsigned h = NUM_HOLES; h > 0; h--)
            if (s_hole[idx][h-1]) r_hn = 3'(h-1);
      end else begin
         for (int unsigned j = NUM_BALLS; j > 0; j--)
            if (s_pair[idx][j-1]) begin
               partner = IW'(j-1);
               found   = 1'b1;
            end
         if (found) begin
            r_vx = s_vx[partner];
            r_vy = s_vy[partner];
         end
         if (s_bord[idx]) begin
            if (int'(s_bx[idx]) <= LEFT_OFFSET + EDGE)       r_vx = sat_abs(r_vx);
            else if (int'(s_bx[idx]) >= RIGHT_OFFSET - EDGE) r_vx = -sat_abs(r_vx);
            if (int'(s_by[idx]) <= TOP_OFFSET + EDGE)        r_vy = sat_abs(r_vy);
            else if (int'(s_by[idx]) >= DOWN_OFFSET - EDGE)  r_vy = -sat_abs(r_vy);
         end
         r_coll = found | s_bord[idx];
         if (!r_coll) begin
            r_vx = '0;
            r_vy = '0;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state     <= COLLECT;
         idx       <= '0;
         overrun_q <= 1'b0;
         bord_hit  <= '0;
         s_bord    <= '0;
         o_coll    <= '0;
         o_hh      <= '0;
         for (int unsigned i = 0; i < NUM_BALLS; i++) begin
            bord_x[i] <= '0;  bord_y[i] <= '0;  hole_mask[i] <= '0;  pair[i] <= '0;
            s_bx[i]   <= '0;  s_by[i]   <= '0;  s_hole[i]    <= '0;  s_pair[i] <= '0;
            s_vx[i]   <= '0;  s_vy[i]   <= '0;
            o_vx[i]   <= '0;  o_vy[i]   <= '0;  o_hn[i]      <= '0;
         end
      end else begin
         // A startOfFrame cycle's own overlap belongs to the new frame, so it restarts the accumulators.
         for (int unsigned i = 0; i < NUM_BALLS; i++) begin
            bord_hit[i]  <= (bord_hit[i] & ~sof) | (bus.ballDR[i] & bus.bordersDR);
            if (bus.ballDR[i] && bus.bordersDR && (sof || !bord_hit[i])) begin
               bord_x[i] <= bus.pixelX;
               bord_y[i] <= bus.pixelY;
            end
            hole_mask[i] <= (sof ? '0 : hole_mask[i]) | ({NUM_HOLES{bus.ballDR[i]}} & bus.holeDR);
            for (int unsigned j = 0; j < NUM_BALLS; j++)
               if (i != j)
                  pair[i][j] <= (pair[i][j] & ~sof) | (bus.ballDR[i] & bus.ballDR[j]);
         end

         case (state)
            COLLECT: begin
               if (sof) begin
                  s_bord <= bord_hit;
                  for (int unsigned i = 0; i < NUM_BALLS; i++) begin
                     s_bx[i]   <= bord_x[i];
                     s_by[i]   <= bord_y[i];
                     s_hole[i] <= hole_mask[i];
                     s_pair[i] <= pair[i];
                     s_vx[i]   <= bus.ballVelX[i*11 +: 11];
                     s_vy[i]   <= bus.ballVelY[i*11 +: 11];
                  end
                  idx   <= '0;
                  state <= RESOLVE;
               end
            end
            RESOLVE: begin
               o_vx[idx]   <= r_vx;
               o_vy[idx]   <= r_vy;
               o_hn[idx]   <= r_hn;
               o_coll[idx] <= r_coll;
               o_hh[idx]   <= r_hh;
               if (sof) overrun_q <= 1'b1;
               if (idx == IW'(NUM_BALLS-1)) state <= DONE;
               else                         idx   <= idx + 1'b1;
            end
            default: begin
               if (sof) overrun_q <= 1'b1;
               state <= COLLECT;
            end
         endcase
      end
   end

   always_comb begin
      bus.ballVelXOut = '0;
      bus.ballVelYOut = '0;
      bus.holeNum     = '0;
      for (int unsigned i = 0; i < NUM_BALLS; i++) begin
         bus.ballVelXOut[i*11 +: 11] = o_vx[i];
         bus.ballVelYOut[i*11 +: 11] = o_vy[i];
         bus.holeNum[i*3 +: 3]       = o_hn[i];
      end
   end

   assign bus.collisionOccurred = o_coll;
   assign bus.holeHit           = o_hh;
   assign bus.resultValid       = (state == DONE);
   assign bus.overrun           = overrun_q;
endmodule

// File: tb/tb_multi_ball_hit_controller.sv
// Directed scoreboard bench for multi_ball_hit_controller with two balls and six holes.
module tb_multi_ball_hit_controller;
   logic clk = 1'b0;
   logic reset = 1'b1;
   int   cyc = 0;
   int   checks = 0;
   int   errors = 0;
   int   pushes = 0;
   int   rv_count = 0;

   typedef struct packed {
      logic [21:0] vx;
      logic [21:0] vy;
      logic [1:0]  coll;
      logic [1:0]  hh;
      logic [5:0]  hn;
      logic        ovr;
      int          cyc;
   } exp_t;

   exp_t q[$];

   multi_ball_hit_controller_if #(.NUM_BALLS(2), .NUM_HOLES(6)) bus ();

   multi_ball_hit_controller #(.NUM_BALLS(2), .NUM_HOLES(6)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
      end
   endtask

   function automatic logic [21:0] v2(input int b0, input int b1);
      return {11'(b1), 11'(b0)};
   endfunction

   function automatic exp_t mk(input logic [21:0] vx, input logic [21:0] vy, input logic [1:0] coll,
                               input logic [1:0] hh, input logic [5:0] hn, input logic ovr);
      exp_t e;
      e.vx = vx;  e.vy = vy;  e.coll = coll;  e.hh = hh;  e.hn = hn;  e.ovr = ovr;  e.cyc = 0;
      return e;
   endfunction

   // Monitor: every resultValid pulse must match the oldest outstanding expectation.
   always @(negedge clk) begin
      if (bus.resultValid === 1'b1) begin
         rv_count++;
         if (q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_valid: got resultValid=1 at cycle %0d expected none", cyc);
         end else begin
            exp_t e;
            e = q.pop_front();
            chk("latency", cyc, e.cyc);
            chk("velX", 32'(bus.ballVelXOut), 32'(e.vx));
            chk("velY", 32'(bus.ballVelYOut), 32'(e.vy));
            chk("collision", 32'(bus.collisionOccurred), 32'(e.coll));
            chk("holeHit", 32'(bus.holeHit), 32'(e.hh));
            chk("holeNum", 32'(bus.holeNum), 32'(e.hn));
            chk("overrun", 32'(bus.overrun), 32'(e.ovr));
         end
      end
   end

   task automatic pixel(input logic [1:0] dr, input logic bord, input logic [5:0] hole,
                        input int x, input int y);
      bus.ballDR    = dr;
      bus.bordersDR = bord;
      bus.holeDR    = hole;
      bus.pixelX    = 11'(x);
      bus.pixelY    = 11'(y);
      @(negedge clk);
      bus.ballDR    = '0;
      bus.bordersDR = 1'b0;
      bus.holeDR    = '0;
   endtask

   task automatic frame(input logic [21:0] vx, input logic [21:0] vy, input bit push, input exp_t e);
      exp_t ee;
      bus.ballVelX     = vx;
      bus.ballVelY     = vy;
      bus.startOfFrame = 1'b1;
      if (push) begin
         ee     = e;
         ee.cyc = cyc + 3;
         q.push_back(ee);
         pushes++;
      end
      @(negedge clk);
      bus.startOfFrame = 1'b0;
   endtask

   task automatic drain();
      for (int k = 0; k < 20 && q.size() != 0; k++) @(negedge clk);
      if (q.size() != 0) begin
         checks++;
         errors++;
         $display("FAIL timeout: got %0d pending results expected 0", q.size());
         q.delete();
      end
      repeat (3) @(negedge clk);
   endtask

   task automatic check_idle(input string tag);
      chk({tag, "_velX"}, 32'(bus.ballVelXOut), 32'd0);
      chk({tag, "_velY"}, 32'(bus.ballVelYOut), 32'd0);
      chk({tag, "_coll"}, 32'(bus.collisionOccurred), 32'd0);
      chk({tag, "_holeHit"}, 32'(bus.holeHit), 32'd0);
      chk({tag, "_holeNum"}, 32'(bus.holeNum), 32'd0);
      chk({tag, "_valid"}, 32'(bus.resultValid), 32'd0);
      chk({tag, "_overrun"}, 32'(bus.overrun), 32'd0);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: got no finish expected finish before 100000 ns");
      $fatal(1, "watchdog");
   end

   initial begin
      exp_t none;
      none = mk('0, '0, '0, '0, '0, 1'b0);
      bus.startOfFrame = 1'b0;
      bus.pixelX       = '0;
      bus.pixelY       = '0;
      bus.ballDR       = '0;
      bus.bordersDR    = 1'b0;
      bus.holeDR       = '0;
      bus.ballVelX     = '0;
      bus.ballVelY     = '0;
      repeat (3) @(negedge clk);
      check_idle("reset");
      reset = 1'b0;
      @(negedge clk);

      // left border bounce
      pixel(2'b01, 1'b1, 6'b0, 4, 200);
      frame(v2(-5, 0), v2(3, 0), 1'b1, mk(v2(5, 0), v2(3, 0), 2'b01, 2'b00, 6'd0, 1'b0));
      drain();

      // ball-ball exchange
      pixel(2'b11, 1'b0, 6'b0, 300, 200);
      frame(v2(4, -2), v2(0, 1), 1'b1, mk(v2(-2, 4), v2(1, 0), 2'b11, 2'b00, 6'd0, 1'b0));
      drain();

      // ball1 in holes 4 and 2: lowest index reported
      pixel(2'b10, 1'b0, 6'b010100, 120, 90);
      frame(v2(3, 5), v2(3, -6), 1'b1, mk('0, '0, 2'b10, 2'b10, {3'd2, 3'd0}, 1'b0));
      drain();

      // corner with -1024 saturation, top border, first border hit position wins
      pixel(2'b01, 1'b1, 6'b0, 635, 476);
      pixel(2'b10, 1'b1, 6'b0, 100, 3);
      pixel(2'b01, 1'b1, 6'b0, 300, 100);
      frame(v2(-1024, 6), v2(7, -9), 1'b1, mk(v2(-1023, 6), v2(-7, 9), 2'b11, 2'b00, 6'd0, 1'b0));
      drain();

      // partner sinks in hole 5; ball0 still takes partner's velocity
      pixel(2'b11, 1'b0, 6'b0, 50, 50);
      pixel(2'b10, 1'b0, 6'b100000, 60, 60);
      frame(v2(1, -3), v2(2, -4), 1'b1, mk(v2(-3, 0), v2(-4, 0), 2'b11, 2'b10, {3'd5, 3'd0}, 1'b0));
      drain();

      // second startOfFrame one cycle into RESOLVE
      pixel(2'b01, 1'b1, 6'b0, 4, 200);
      frame(v2(-5, 0), v2(3, 0), 1'b1, mk(v2(5, 0), v2(3, 0), 2'b01, 2'b00, 6'd0, 1'b1));
      frame(v2(9, 9), v2(9, 9), 1'b0, none);
      drain();
      repeat (5) @(negedge clk);

      // reset while resolving
      pixel(2'b01, 1'b1, 6'b0, 4, 200);
      frame(v2(-5, 0), v2(3, 0), 1'b0, none);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      check_idle("midreset");
      repeat (6) @(negedge clk);

      pixel(2'b11, 1'b0, 6'b0, 300, 200);
      frame(v2(4, -2), v2(0, 1), 1'b1, mk(v2(-2, 4), v2(1, 0), 2'b11, 2'b00, 6'd0, 1'b0));
      drain();

      chk("valid_count", 32'(rv_count), 32'(pushes));
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule

// File: doc/multi_ball_hit_controller.md
Name: multi_ball_hit_controller

Overview:
Per-frame collision resolver for NUM_BALLS balls against table borders, pocket holes and each other. It accumulates pixel-level overlaps (drawing-request coincidences) during a video frame and snapshots them at startOfFrame. It then resolves one ball per clock into registered output velocities and collision/hole flags, and pulses resultValid. It sits between the object drawers and the ball movement blocks, replacing the two-ball, border-only controller.

Parameters:
NUM_BALLS, 2, number of balls (2..8); ball i occupies slice i of every packed bus
NUM_HOLES, 6, number of hole drawers (1..8)
TOP_OFFSET, 0, table top border row
DOWN_OFFSET, 479, table bottom border row
LEFT_OFFSET, 0, table left border column
RIGHT_OFFSET, 639, table right border column
EDGE, 8, pixel band inside each offset that classifies a border hit as that side

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
startOfFrame  in  1  one-cycle pulse at frame boundary
pixelX  in  11  current scan column, unsigned
pixelY  in  11  current scan row, unsigned
ballDR  in  NUM_BALLS  per-ball drawing request
bordersDR  in  1  border drawing request
holeDR  in  NUM_HOLES  per-hole drawing request
ballVelX  in  NUM_BALLS*11  signed X velocity, ball i at [11i+10:11i]
ballVelY  in  NUM_BALLS*11  signed Y velocity, same packing
ballVelXOut  out  NUM_BALLS*11  resolved X velocity
ballVelYOut  out  NUM_BALLS*11  resolved Y velocity
collisionOccurred  out  NUM_BALLS  per-ball collision flag for the last frame
holeHit  out  NUM_BALLS  per-ball hole flag
holeNum  out  NUM_BALLS*3  lowest hole index hit, ball i at [3i+2:3i]
resultValid  out  1  one-cycle pulse: all outputs updated
overrun  out  1  sticky flag: startOfFrame arrived while resolving

Behaviour:
- Reset: all outputs 0; accumulators, snapshots and overrun cleared; FSM goes to COLLECT.
- Live accumulators, updated every cycle in every state:
  - bordHit[i] |= ballDR[i] & bordersDR. On the first such hit in the frame, store pixelX/pixelY as bordPos[i].
  - holeMask[i][h] |= ballDR[i] & holeDR[h].
  - pair[i][j] (i<j) |= ballDR[i] & ballDR[j].
- FSM states are COLLECT, RESOLVE and DONE.
- COLLECT with startOfFrame:
  - Copy the accumulators and the ballVelX/ballVelY inputs into snapshot registers.
  - Clear the live accumulators in the same cycle; a current-cycle event goes to the new frame.
  - Set idx=0 and go to RESOLVE.
- RESOLVE, one ball per cycle (ball idx), all from snapshot values:
  - If any holeMask bit is set: velocity out = 0, holeHit=1, holeNum = lowest set h, collision=1.
  - Otherwise start from v = snapshot velocity.
    - If any pair involving idx is set, v = the partner's snapshot velocity, using the lowest-index partner (equal-mass exchange).
    - Then, if bordHit: x<=LEFT_OFFSET+EDGE gives vx=|vx|; x>=RIGHT_OFFSET-EDGE gives vx=-|vx|; y<=TOP_OFFSET+EDGE gives vy=|vy|; y>=DOWN_OFFSET-EDGE gives vy=-|vy|. Corners apply both.
    - If any of ball-ball or border applied: collision=1 and velocity out = v; holeHit=0, holeNum=0.
    - If none applied: all of that ball's outputs = 0.
  - idx increments; after idx=NUM_BALLS-1 go to DONE.
- DONE: resultValid=1 for one cycle, then return to COLLECT.
- Latency: startOfFrame at cycle t → ball i outputs update at edge t+2+i → resultValid high in cycle t+NUM_BALLS+1.
- Outputs hold their values until rewritten by the next RESOLVE.
- Arithmetic: 11-bit two's complement. |−1024| and −(−1024) saturate to +1023 and −1023 respectively. No other width growth.
- startOfFrame in RESOLVE or DONE: set overrun (it stays set until reset). That frame's snapshot is dropped. The live accumulators are still cleared.
- Reset mid-RESOLVE: the next cycle is COLLECT, outputs 0, and no resultValid.

Test Plan:
- Ball0 bordersDR at (4,200), vel (−5,3); startOfFrame → ball0 out (5,3), collision[0]=1, ball1 outputs 0, resultValid 3 cycles after startOfFrame (NUM_BALLS=2).
- Balls 0/1 overlap one pixel at (300,200), vels (4,0)/(−2,1) → ball0 out (−2,1), ball1 out (4,0), both collision=1.
- Ball1 overlaps holeDR[4] and holeDR[2] → holeHit[1]=1, holeNum[1]=2, ball1 vel out (0,0), collision[1]=1.
- Ball0 at corner (635,476), vel (−1024,7) border hit → out (−1023,−7).
- Second startOfFrame one cycle into RESOLVE → overrun=1, first frame's result still delivered, no second resultValid.
- reset asserted during RESOLVE → next cycle all outputs 0; the following startOfFrame is resolved normally.
